// File: rtl/ad9228_fco_aligner_if.sv
// Lane-side signal bundle of the AD9228 FCO word aligner: the deserialised FCO/data words
// going in, the aligned data, frame marker and alignment status coming out.
interface ad9228_fco_aligner_if;
   logic [7:0] fco_word;
   logic [7:0] data_in;
   logic       data_valid_in;
   logic [7:0] data_out;
   logic       data_valid_out;
   logic       frame_start;
   logic       bitslip;
   logic       locked;
   logic [3:0] slip_count;
   logic       align_error;

   modport master (
      output fco_word, data_in, data_valid_in,
      input  data_out, data_valid_out, frame_start, bitslip, locked, slip_count, align_error
   );

   modport slave (
      input  fco_word, data_in, data_valid_in,
      output data_out, data_valid_out, frame_start, bitslip, locked, slip_count, align_error
   );
endinterface

// File: rtl/ad9228_fco_aligner.sv
// Word aligner for the AD9228 lanes: bitslips the ISERDES pair until the FCO stream follows the
// FC/0F/C0 frame sequence, then forwards data words tagged with the 2-sample group start.
module ad9228_fco_aligner #(
   parameter logic [7:0] PAT0         = 8'hFC,
   parameter logic [7:0] PAT1         = 8'h0F,
   parameter logic [7:0] PAT2         = 8'hC0,
   parameter int         SETTLE_WORDS = 4,
   parameter int         LOCK_COUNT   = 16,
   parameter int         UNLOCK_COUNT = 4,
   parameter int         MAX_SLIPS    = 8
) (
   input  logic                 data_in_clk,
   input  logic                 rstn,
   ad9228_fco_aligner_if.slave  lane
);

   typedef enum logic [1:0] {SEARCH, SLIP_WAIT, VERIFY, LOCKED} state_t;

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int UW = $clog2(UNLOCK_COUNT + 1);
   localparam int SW = $clog2(SETTLE_WORDS + 1);
   localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_COUNT - 1);
   localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_COUNT - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_WORDS - 1);
   localparam logic [3:0]    SLIP_LAST   = 4'(MAX_SLIPS - 1);

   function automatic logic [7:0] pat_of(input logic [1:0] p);
      case (p)
         2'd0:    return PAT0;
         2'd1:    return PAT1;
         default: return PAT2;
      endcase
   endfunction

   function automatic logic [1:0] next_phase(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   state_t        state,      state_nxt;
   logic [1:0]    phase,      phase_nxt;
   logic [MW-1:0] match_cnt,  match_nxt;
   logic [UW-1:0] miss_cnt,   miss_nxt;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic [3:0]    slips,      slips_nxt;
   logic          err,        err_nxt;
   logic          locked_r,   locked_nxt;
   logic          slip_r,     slip_nxt;
   logic          hit;

   logic [7:0]    data_q;
   logic          dv_q;
   logic          fs_q;

   // phase always names the group position the current FCO word should occupy
   assign hit = (lane.fco_word == pat_of(phase));

   always_ff @(posedge data_in_clk or negedge rstn) begin
      if (!rstn) begin
         state      <= SEARCH;
         phase      <= 2'd0;
         match_cnt  <= '0;
         miss_cnt   <= '0;
         settle_cnt <= '0;
         slips      <= '0;
         err        <= 1'b0;
         locked_r   <= 1'b0;
         slip_r     <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         state      <= state_nxt;
         phase      <= phase_nxt;
         match_cnt  <= match_nxt;
         miss_cnt   <= miss_nxt;
         settle_cnt <= settle_nxt;
         slips      <= slips_nxt;
         err        <= err_nxt;
         locked_r   <= locked_nxt;
         slip_r     <= slip_nxt;
      end
   end

   always_comb begin
      // NOTE: every variable gets a hold/default value first so no latch is inferred.
      state_nxt  = state;
      phase_nxt  = phase;
      match_nxt  = match_cnt;
      miss_nxt   = miss_cnt;
      settle_nxt = settle_cnt;
      slips_nxt  = slips;
      err_nxt    = err;
      locked_nxt = locked_r;
      slip_nxt   = 1'b0;

      if (lane.data_valid_in) begin
         unique case (state)
            SEARCH: begin
               if (lane.fco_word == PAT0 || lane.fco_word == PAT1 || lane.fco_word == PAT2) begin
                  phase_nxt = (lane.fco_word == PAT0) ? 2'd1 :
                              (lane.fco_word == PAT1) ? 2'd2 : 2'd0;
                  match_nxt = MW'(1);
                  state_nxt = VERIFY;
               end else begin
                  slip_nxt   = 1'b1;
                  settle_nxt = '0;
                  state_nxt  = SLIP_WAIT;
                  if (slips == SLIP_LAST) begin
                     slips_nxt = '0;
                     err_nxt   = 1'b1;
                  end else begin
                     slips_nxt = slips + 4'd1;
                  end
               end
            end
            SLIP_WAIT: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_nxt = '0;
                  state_nxt  = SEARCH;
               end else begin
                  settle_nxt = settle_cnt + 1'b1;
               end
            end
            VERIFY: begin
               if (hit) begin
                  match_nxt = match_cnt + 1'b1;
                  phase_nxt = next_phase(phase);
                  if (match_cnt == LOCK_LAST) begin
                     state_nxt  = LOCKED;
                     locked_nxt = 1'b1;
                     slips_nxt  = '0;
                     miss_nxt   = '0;
                  end
               end else begin
                  match_nxt = '0;
                  state_nxt = SEARCH;
               end
            end
            LOCKED: begin
               phase_nxt = next_phase(phase);
               if (hit) begin
                  miss_nxt = '0;
               end else if (miss_cnt == UNLOCK_LAST) begin
                  miss_nxt   = '0;
                  match_nxt  = '0;
                  locked_nxt = 1'b0;
                  state_nxt  = SEARCH;
               end else begin
                  miss_nxt = miss_cnt + 1'b1;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   // Forwarding uses the lock flag as it stood before this word, so the locking word is dropped.
   always_ff @(posedge data_in_clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
         dv_q   <= 1'b0;
         fs_q   <= 1'b0;
      end else begin
         if (lane.data_valid_in) data_q <= lane.data_in;
         dv_q <= lane.data_valid_in & locked_r;
         fs_q <= lane.data_valid_in & locked_r & (phase == 2'd0);
      end
   end

   assign lane.data_out       = data_q;
   assign lane.data_valid_out = dv_q;
   assign lane.frame_start    = fs_q;
   assign lane.bitslip        = slip_r;
   assign lane.locked         = locked_r;
   assign lane.slip_count     = slips;
   assign lane.align_error    = err;

endmodule

// File: tb/tb_ad9228_fco_aligner.sv
// Self-checking bench: a bit-level FCO/ISERDES stream model feeds the aligner and a word-level
// reference model predicts every output each cycle.
module tb_ad9228_fco_aligner;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ad9228_fco_aligner_if lane();

   ad9228_fco_aligner dut (
      .data_in_clk (clk),
      .rstn        (rstn),
      .lane        (lane)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Stream source: 12-bit frame 111111000000, window of 8 bits starting at pos; a slip moves it 1 bit.
   localparam logic [11:0] FRAME = 12'b1111_1100_0000;
   int pos = 0;

   function automatic logic [7:0] word_at(input int p);
      logic [7:0] w;
      for (int b = 0; b < 8; b++) w[7-b] = FRAME[11 - ((p + b) % 12)];
      return w;
   endfunction

   // Reference model: mode 0 hunt, 1 settling, 2 confirming, 3 locked.
   logic [7:0] pats [3] = '{8'hFC, 8'h0F, 8'hC0};
   int         m_mode, m_next, m_run, m_miss, m_settle, m_slips;
   bit         m_err, m_locked, m_slip, m_dv, m_fs;
   logic [7:0] m_dout;

   task automatic model_reset();
      m_mode = 0; m_next = 0; m_run = 0; m_miss = 0; m_settle = 0; m_slips = 0;
      m_err = 0; m_locked = 0; m_slip = 0; m_dv = 0; m_fs = 0; m_dout = 8'h00;
   endtask

   task automatic model_word(input bit v, input logic [7:0] f, input logic [7:0] d);
      int k;
      m_slip = 0;
      if (!v) begin
         m_dv = 0;
         m_fs = 0;
         return;
      end
      m_dout = d;
      m_dv   = m_locked;
      m_fs   = m_locked && (m_next == 0);
      k = -1;
      for (int i = 0; i < 3; i++) if (f == pats[i]) k = i;
      case (m_mode)
         0: if (k >= 0) begin
               m_next = (k + 1) % 3; m_run = 1; m_mode = 2;
            end else begin
               m_slip = 1; m_settle = 0; m_mode = 1;
               m_slips = m_slips + 1;
               if (m_slips == 8) begin m_err = 1; m_slips = 0; end
            end
         1: begin
               m_settle = m_settle + 1;
               if (m_settle == 4) m_mode = 0;
            end
         2: if (f == pats[m_next]) begin
               m_run = m_run + 1; m_next = (m_next + 1) % 3;
               if (m_run == 16) begin m_mode = 3; m_locked = 1; m_slips = 0; m_miss = 0; end
            end else begin
               m_run = 0; m_mode = 0;
            end
         default: begin
               m_miss = (f == pats[m_next]) ? 0 : m_miss + 1;
               m_next = (m_next + 1) % 3;
               if (m_miss == 4) begin m_locked = 0; m_mode = 0; m_miss = 0; end
            end
      endcase
   endtask

   task automatic compare_all();
      check("data_out",       32'(lane.data_out),       32'(m_dout));
      check("data_valid_out", 32'(lane.data_valid_out), 32'(m_dv));
      check("frame_start",    32'(lane.frame_start),    32'(m_fs));
      check("bitslip",        32'(lane.bitslip),        32'(m_slip));
      check("locked",         32'(lane.locked),         32'(m_locked));
      check("slip_count",     32'(lane.slip_count),     32'(m_slips));
      check("align_error",    32'(lane.align_error),    32'(m_err));
   endtask

   // kind: 0 clean stream word, 1 corrupted word, 2 constant 8'h00
   task automatic step(input bit v, input int kind);
      logic [7:0] f, d;
      bit         slipping;
      f = word_at(pos);
      if (kind == 1) f = f ^ 8'h81;
      if (kind == 2) f = 8'h00;
      if (!v) f = 8'($urandom);
      d = 8'($urandom);
      lane.data_valid_in = v;
      lane.fco_word      = f;
      lane.data_in       = d;
      @(posedge clk);
      slipping = m_slip;
      model_word(v, f, d);
      if (v) pos = (pos + 8) % 12;
      if (slipping) pos = (pos + 1) % 12;
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset(input int start_pos);
      rstn = 1'b0;
      #1;
      check("rst_bitslip",    32'(lane.bitslip),        0);
      check("rst_locked",     32'(lane.locked),         0);
      check("rst_slip_count", 32'(lane.slip_count),     0);
      check("rst_align_err",  32'(lane.align_error),    0);
      check("rst_dv",         32'(lane.data_valid_out), 0);
      check("rst_data",       32'(lane.data_out),       0);
      model_reset();
      pos = start_pos;
      lane.data_valid_in = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      compare_all();
   endtask

   int slips_seen;

   initial begin
      lane.data_valid_in = 1'b0;
      lane.fco_word      = 8'h00;
      lane.data_in       = 8'h00;
      model_reset();
      @(negedge clk);
      do_reset(0);

      // Pre-aligned stream: no slips, lock on the 16th word, frame_start on FC words.
      slips_seen = 0;
      for (int i = 0; i < 15; i++) begin step(1, 0); slips_seen += int'(lane.bitslip); end
      check("pre_not_yet", 32'(lane.locked), 0);
      step(1, 0);
      check("pre_locked", 32'(lane.locked), 1);
      for (int i = 0; i < 9; i++) begin step(1, 0); slips_seen += int'(lane.bitslip); end
      check("pre_no_slip", 32'(slips_seen), 0);

      // Corruption tolerance, then loss of lock.
      for (int i = 0; i < 3; i++) step(1, 1);
      step(1, 0);
      check("miss3_locked", 32'(lane.locked), 1);
      for (int i = 0; i < 4; i++) step(1, 1);
      check("miss4_unlock", 32'(lane.locked), 0);
      step(1, 0);
      check("miss4_dv", 32'(lane.data_valid_out), 0);
      for (int i = 0; i < 20; i++) step(1, 0);

      // 2-bit offset: exactly two slips, then lock with slip_count back at 0.
      do_reset(2);
      slips_seen = 0;
      for (int i = 0; i < 40; i++) begin step(1, 0); slips_seen += int'(lane.bitslip); end
      check("off2_slips", 32'(slips_seen), 2);
      check("off2_locked", 32'(lane.locked), 1);
      check("off2_slip_cnt", 32'(lane.slip_count), 0);

      // Constant zero FCO: eighth slip on word 36 raises align_error.
      do_reset(0);
      for (int i = 0; i < 35; i++) step(1, 2);
      check("zero_err_pre", 32'(lane.align_error), 0);
      step(1, 2);
      check("zero_err", 32'(lane.align_error), 1);
      for (int i = 0; i < 4; i++) step(1, 2);
      check("zero_slip_cnt", 32'(lane.slip_count), 0);
      check("zero_locked", 32'(lane.locked), 0);

      // Alternating valid: lock needs 16 valid words.
      do_reset(0);
      for (int i = 0; i < 30; i++) step(i % 2 == 0, 0);
      check("tog_pre", 32'(lane.locked), 0);
      step(1, 0);
      check("tog_locked", 32'(lane.locked), 1);
      for (int i = 0; i < 12; i++) step(i % 2 == 1, 0);

      // Reset while a bitslip pulse is out, then a clean re-lock.
      do_reset(2);
      step(1, 0);
      check("mid_pulse", 32'(lane.bitslip), 1);
      do_reset(0);
      for (int i = 0; i < 20; i++) step(1, 0);
      check("relock", 32'(lane.locked), 1);

      // Random offsets, gaps and occasional corruption.
      for (int r = 0; r < 4; r++) begin
         do_reset(int'($urandom_range(0, 11)));
         for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, ($urandom_range(0, 39) == 0) ? 1 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
